rs_issue_sched: RTL and testbench

Issue scheduler for the reservation station. Each cycle it chooses which ready RS entry is sent to the ALU and drives the station's front/front_pos. Selection is oldest-first by ROB age relative to the ROB head. It also handles ALU backpressure, flush, and the one-cycle window before the station clears busy on an issued entry.

---
 rtl/rs_issue_sched_pkg.sv | 20 ++
 rtl/rs_issue_sched_if.sv | 42 ++++
 rtl/rs_issue_sched_age_select.sv | 37 +++
 rtl/rs_issue_sched.sv | 125 ++++++++++++
 tb/tb_rs_issue_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rs_issue_sched_pkg.sv
// rs_issue_sched_pkg: shared sizes and FSM state encoding for the
// reservation-station issue scheduler.
//   RS_SIZ  - number of RS entries
//   RS_LEN  - RS index width
//   ROB_LEN - ROB index width (ROB depth is 2**ROB_LEN)
//   sched_state_e - scheduler FSM states, 2-bit encoding visible on sched_state
package rs_issue_sched_pkg;

  localparam int RS_SIZ  = 16;
  localparam int RS_LEN  = 4;
  localparam int ROB_LEN = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_HOLD  = 2'd2,
    SCHED_FLUSH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rs_issue_sched_if.sv
// rs_issue_sched_if: station/ALU-facing signals of the issue scheduler.
//   master : station side; drives ready, flush, rs_* vectors, rob_head, alu_busy
//   slave  : scheduler; drives front, front_pos, sched_state
//            (plus stat_issued / stat_stall when ISSUE_STATS_EN is defined)
interface rs_issue_sched_if
  import rs_issue_sched_pkg::*;
#(
  parameter int RS_SIZ = rs_issue_sched_pkg::RS_SIZ,
  parameter int RS_W   = rs_issue_sched_pkg::RS_LEN,
  parameter int ROB_W  = rs_issue_sched_pkg::ROB_LEN
);
  logic                    ready;
  logic                    flush;
  logic [RS_SIZ-1:0]       rs_busy_vec;
  logic [RS_SIZ-1:0]       rs_rdy_vec;
  logic [RS_SIZ*ROB_W-1:0] rs_robpos_flat;
  logic [ROB_W-1:0]        rob_head;
  logic                    alu_busy;
  logic                    front;
  logic [RS_W-1:0]         front_pos;
  logic [1:0]              sched_state;
`ifdef ISSUE_STATS_EN
  logic [31:0]             stat_issued;
  logic [31:0]             stat_stall;
`endif

  modport master (
    output ready, flush, rs_busy_vec, rs_rdy_vec, rs_robpos_flat, rob_head, alu_busy,
`ifdef ISSUE_STATS_EN
    input  stat_issued, stat_stall,
`endif
    input  front, front_pos, sched_state
  );

  modport slave (
    input  ready, flush, rs_busy_vec, rs_rdy_vec, rs_robpos_flat, rob_head, alu_busy,
`ifdef ISSUE_STATS_EN
    output stat_issued, stat_stall,
`endif
    output front, front_pos, sched_state
  );
endinterface

// File: rtl/rs_issue_sched_age_select.sv
// rs_issue_sched_age_select: combinational oldest-first picker.
//   cand        - candidate entries
//   robpos_flat - entry i ROB position at [i*ROB_W +: ROB_W]
//   rob_head    - current ROB head (age reference)
//   winner      - candidate with minimum (robpos - rob_head) mod 2**ROB_W,
//                 lowest index on ties
//   any_vld     - at least one candidate present
module rs_issue_sched_age_select #(
  parameter int RS_SIZ = 16,
  parameter int RS_W   = 4,
  parameter int ROB_W  = 4
) (
  input  logic [RS_SIZ-1:0]       cand,
  input  logic [RS_SIZ*ROB_W-1:0] robpos_flat,
  input  logic [ROB_W-1:0]        rob_head,
  output logic [RS_W-1:0]         winner,
  output logic                    any_vld
);
  logic [ROB_W-1:0] age;
  logic [ROB_W-1:0] best_age;

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    winner   = '0;
    any_vld  = 1'b0;
    best_age = '1;
    age      = '0;
    for (int i = 0; i < RS_SIZ; i++) begin
      age = robpos_flat[i*ROB_W +: ROB_W] - rob_head;
      if (cand[i] && (!any_vld || (age < best_age))) begin
        winner   = RS_W'(i);
        best_age = age;
        any_vld  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: reservation-station issue scheduler. Picks the oldest ready
// entry (by ROB age relative to head) and issues it to the ALU as a registered
// one-cycle front pulse with front_pos.
//   clk, reset (async, active low)
//   bus : rs_issue_sched_if.slave (station inputs, front/front_pos/sched_state)
// Optional macro ISSUE_STATS_EN adds saturating stat_issued / stat_stall counters.
//
// state | meaning
// IDLE  | no candidate
// ISSUE | front=1, front_pos = winner latched on entry
// HOLD  | candidate pending, ALU busy
// FLUSH | one-cycle flush recovery, then IDLE
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int RS_SIZ = rs_issue_sched_pkg::RS_SIZ,
  parameter int RS_W   = rs_issue_sched_pkg::RS_LEN,
  parameter int ROB_W  = rs_issue_sched_pkg::ROB_LEN
) (
  input logic          clk,
  input logic          reset,
  rs_issue_sched_if.slave bus
);
  sched_state_e      state_q, state_d;
  logic [RS_W-1:0]   front_pos_q, front_pos_d;
  logic [RS_W-1:0]   last_pos_q, last_pos_d;
  logic              last_vld_q, last_vld_d;
  logic [RS_SIZ-1:0] cand;
  logic [RS_W-1:0]   winner;
  logic              any_vld;

  // The station clears busy one edge after front, so the entry just issued
  // is masked out for that cycle to avoid a duplicate issue.
  always_comb begin
    cand = bus.rs_busy_vec & bus.rs_rdy_vec;
    if (last_vld_q) cand[last_pos_q] = 1'b0;
  end

  rs_issue_sched_age_select #(
    .RS_SIZ (RS_SIZ),
    .RS_W   (RS_W),
    .ROB_W  (ROB_W)
  ) u_age_select (
    .cand        (cand),
    .robpos_flat (bus.rs_robpos_flat),
    .rob_head    (bus.rob_head),
    .winner      (winner),
    .any_vld     (any_vld)
  );

  always_comb begin
    state_d     = state_q;
    front_pos_d = front_pos_q;
    last_pos_d  = last_pos_q;
    last_vld_d  = last_vld_q;
    if (bus.ready) begin
      if (bus.flush) begin
        state_d = SCHED_FLUSH;
      end else begin
        case (state_q)
          SCHED_FLUSH: state_d = SCHED_IDLE;
          default: begin
            if (!any_vld)          state_d = SCHED_IDLE;
            else if (bus.alu_busy) state_d = SCHED_HOLD;
            else                   state_d = SCHED_ISSUE;
          end
        endcase
      end
      last_vld_d = (state_d == SCHED_ISSUE);
      last_pos_d = winner;
      if (state_d == SCHED_ISSUE) front_pos_d = winner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCHED_IDLE;
      front_pos_q <= '0;
      last_pos_q  <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_pos_q <= front_pos_d;
      last_pos_q  <= last_pos_d;
      last_vld_q  <= last_vld_d;
    end
  end

  // Gated by ready so a stalled pipeline never sees a pulse.
  assign bus.front       = (state_q == SCHED_ISSUE) && bus.ready;
  assign bus.front_pos   = front_pos_q;
  assign bus.sched_state = state_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (bus.ready) begin
      if (bus.flush) begin
        stat_issued_d = '0;
        stat_stall_d  = '0;
      end else begin
        if ((state_q == SCHED_ISSUE) && (stat_issued_q != '1)) stat_issued_d = stat_issued_q + 32'd1;
        if ((state_q == SCHED_HOLD) && (stat_stall_q != '1))   stat_stall_d  = stat_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign bus.stat_issued = stat_issued_q;
  assign bus.stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: directed vectors and hand-written sequences for the
// reservation-station issue scheduler.
module tb_rs_issue_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rs_issue_sched_if bus_if ();

  rs_issue_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] busy;
    logic [15:0] rdy;
    logic [63:0] rp;
    logic [3:0]  head;
    logic        alu_busy;
    logic        flush;
    logic        exp_front;
    logic [3:0]  exp_pos;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] busy, input logic [15:0] rdy, input logic [63:0] rp,
                       input logic [3:0] head, input logic alu_busy, input logic flush);
    bus_if.rs_busy_vec    = busy;
    bus_if.rs_rdy_vec     = rdy;
    bus_if.rs_robpos_flat = rp;
    bus_if.rob_head       = head;
    bus_if.alu_busy       = alu_busy;
    bus_if.flush          = flush;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus_if.ready = 1'b1;
    drive(16'h0, 16'h0, 64'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          busy      rdy       robpos flat               head  alu  fl  front pos    state
    vecs[0] = '{16'h0088, 16'h0088, 64'h0000_0000_2000_5000, 4'd0,  1'b0, 1'b0, 1'b1, 4'd7,  2'd1};
    vecs[1] = '{16'h0006, 16'h0006, 64'h0000_0000_0000_01F0, 4'd14, 1'b0, 1'b0, 1'b1, 4'd1,  2'd1};
    vecs[2] = '{16'h0220, 16'h0220, 64'h0000_0030_0030_0000, 4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  2'd1};
    vecs[3] = '{16'hFFFF, 16'h0000, 64'h0,                   4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  2'd0};
    vecs[4] = '{16'h0000, 16'hFFFF, 64'h0,                   4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  2'd0};
    vecs[5] = '{16'h0010, 16'h0010, 64'h0000_0000_0001_0000, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  2'd2};
    vecs[6] = '{16'h0004, 16'h0004, 64'h0,                   4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  2'd3};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 64'hFEDC_BA98_7654_3210, 4'd10, 1'b0, 1'b0, 1'b1, 4'd10, 2'd1};
    vecs[8] = '{16'h8001, 16'h8001, 64'h0000_0000_0000_0001, 4'd0,  1'b0, 1'b0, 1'b1, 4'd15, 2'd1};
    vecs[9] = '{16'h0101, 16'h0101, 64'h0000_000E_0000_000F, 4'd15, 1'b0, 1'b0, 1'b1, 4'd0,  2'd1};

    // Reset state
    do_reset();
    chk("reset_front", 32'(bus_if.front), 32'd0);
    chk("reset_pos", 32'(bus_if.front_pos), 32'd0);
    chk("reset_state", 32'(bus_if.sched_state), 32'd0);

    // Single-edge selection vectors, each from a fresh reset
    for (int v = 0; v < 10; v++) begin
      do_reset();
      drive(vecs[v].busy, vecs[v].rdy, vecs[v].rp, vecs[v].head, vecs[v].alu_busy, vecs[v].flush);
      step();
      chk($sformatf("vec%0d_front", v), 32'(bus_if.front), 32'(vecs[v].exp_front));
      chk($sformatf("vec%0d_pos", v), 32'(bus_if.front_pos), 32'(vecs[v].exp_pos));
      chk($sformatf("vec%0d_state", v), 32'(bus_if.sched_state), 32'(vecs[v].exp_state));
    end

    // Back-to-back issue: entry 7 (older) then entry 3
    do_reset();
    drive(16'h0088, 16'h0088, 64'h0000_0000_2000_5000, 4'd0, 1'b0, 1'b0);
    step();
    chk("b2b_first_front", 32'(bus_if.front), 32'd1);
    chk("b2b_first_pos", 32'(bus_if.front_pos), 32'd7);
    step();
    chk("b2b_second_front", 32'(bus_if.front), 32'd1);
    chk("b2b_second_pos", 32'(bus_if.front_pos), 32'd3);
    bus_if.rs_busy_vec = 16'h0008;
    step();
    chk("b2b_masked_front", 32'(bus_if.front), 32'd0);
    chk("b2b_masked_state", 32'(bus_if.sched_state), 32'd0);
    bus_if.rs_busy_vec = 16'h0000;
    step();
    chk("b2b_done_front", 32'(bus_if.front), 32'd0);

    // ALU backpressure: entry 4 held for three cycles, then issued once
    do_reset();
    drive(16'h0010, 16'h0010, 64'h0000_0000_0001_0000, 4'd0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold%0d_state", c), 32'(bus_if.sched_state), 32'd2);
      chk($sformatf("hold%0d_front", c), 32'(bus_if.front), 32'd0);
    end
    bus_if.alu_busy = 1'b0;
    step();
    chk("hold_issue_front", 32'(bus_if.front), 32'd1);
    chk("hold_issue_pos", 32'(bus_if.front_pos), 32'd4);
`ifdef ISSUE_STATS_EN
    chk("hold_stat_stall", bus_if.stat_stall, 32'd3);
`endif
    step();
    chk("hold_once_front", 32'(bus_if.front), 32'd0);
    bus_if.rs_busy_vec = 16'h0000;
    step();
    chk("hold_after_front", 32'(bus_if.front), 32'd0);

    // Entry 6 busy lingers one cycle after issue: no duplicate issue
    do_reset();
    drive(16'h0040, 16'h0040, 64'h0, 4'd0, 1'b0, 1'b0);
    step();
    chk("mask_issue_front", 32'(bus_if.front), 32'd1);
    chk("mask_issue_pos", 32'(bus_if.front_pos), 32'd6);
    step();
    chk("mask_dup_front", 32'(bus_if.front), 32'd0);
    bus_if.rs_busy_vec = 16'h0000;
    step();
    chk("mask_idle_front", 32'(bus_if.front), 32'd0);
    chk("mask_idle_state", 32'(bus_if.sched_state), 32'd0);

    // Flush with entry 2 ready: FLUSH, IDLE, then issue
    do_reset();
    drive(16'h0004, 16'h0004, 64'h0, 4'd0, 1'b0, 1'b1);
    step();
    chk("flush_state", 32'(bus_if.sched_state), 32'd3);
    chk("flush_front", 32'(bus_if.front), 32'd0);
    bus_if.flush = 1'b0;
    step();
    chk("flush_idle_state", 32'(bus_if.sched_state), 32'd0);
    chk("flush_idle_front", 32'(bus_if.front), 32'd0);
    step();
    chk("flush_issue_front", 32'(bus_if.front), 32'd1);
    chk("flush_issue_pos", 32'(bus_if.front_pos), 32'd2);

    // ready=0 holds everything and masks front
    do_reset();
    bus_if.ready = 1'b0;
    drive(16'h0004, 16'h0004, 64'h0, 4'd0, 1'b0, 1'b0);
    step();
    chk("rdy_off_state", 32'(bus_if.sched_state), 32'd0);
    chk("rdy_off_front", 32'(bus_if.front), 32'd0);
    bus_if.ready = 1'b1;
    step();
    chk("rdy_on_front", 32'(bus_if.front), 32'd1);
    bus_if.ready = 1'b0;
    step();
    chk("rdy_hold_state", 32'(bus_if.sched_state), 32'd1);
    chk("rdy_hold_front", 32'(bus_if.front), 32'd0);
    chk("rdy_hold_pos", 32'(bus_if.front_pos), 32'd2);
    bus_if.ready = 1'b1;
    #1;
    chk("rdy_resume_front", 32'(bus_if.front), 32'd1);
    step();
    chk("rdy_resume_next_front", 32'(bus_if.front), 32'd0);

    // Async reset during ISSUE
    do_reset();
    drive(16'h0008, 16'h0008, 64'h0, 4'd0, 1'b0, 1'b0);
    step();
    step();
    chk("arst_mask_front", 32'(bus_if.front), 32'd0);
`ifdef ISSUE_STATS_EN
    chk("arst_stat_before", bus_if.stat_issued, 32'd1);
`endif
    step();
    chk("arst_issue_front", 32'(bus_if.front), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_front", 32'(bus_if.front), 32'd0);
    chk("arst_state", 32'(bus_if.sched_state), 32'd0);
`ifdef ISSUE_STATS_EN
    chk("arst_stat_issued", bus_if.stat_issued, 32'd0);
`endif
    step();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
